sweep_scheduler: RTL and testbench

SWEEP_SCHEDULER -- requirements
Module: sweep_scheduler

---
 rtl/sweep_scheduler.sv | 130 +++++++++++++
 tb/tb_sweep_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: DDS tuning-word sweep sequencer (IDLE/LOAD/DWELL/DONE).
// Define SWEEP_PINGPONG_EN to make the sweep run back down after reaching the top word.
module sweep_scheduler #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        m_start,
    input  logic [31:0]        m_step,
    input  logic [15:0]        n_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic [31:0]        m,
    output logic               set,
    output logic               en,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;
    state_t             state_q, state_d;
    logic [31:0]        m_q, m_d, step_q, step_d;
    logic [15:0]        n_q, n_d, cnt_q, cnt_d;
    logic [DWELL_W-1:0] dw_q, dw_d, dcnt_q, dcnt_d;
    logic               en_q, en_d;
`ifdef SWEEP_PINGPONG_EN
    logic               down_q, down_d;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            step_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            dw_q    <= '0;
            dcnt_q  <= '0;
            en_q    <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            down_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            step_q  <= step_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            dw_q    <= dw_d;
            dcnt_q  <= dcnt_d;
            en_q    <= en_d;
`ifdef SWEEP_PINGPONG_EN
            down_q  <= down_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        step_d  = step_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        dw_d    = dw_q;
        dcnt_d  = dcnt_q;
        en_d    = en_q;
`ifdef SWEEP_PINGPONG_EN
        down_d  = down_q;
`endif
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            en_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (abort) begin
                        en_d = 1'b0;
                    end else if (start) begin
                        step_d  = m_step;
                        n_d     = n_steps;
                        dw_d    = (dwell == '0) ? DWELL_W'(1) : dwell;
                        m_d     = m_start;
                        cnt_d   = '0;
                        en_d    = 1'b1;
`ifdef SWEEP_PINGPONG_EN
                        down_d  = 1'b0;
`endif
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    en_d    = 1'b1;
                    dcnt_d  = dw_q - DWELL_W'(1);
                    state_d = DWELL;
                end
                DWELL: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - DWELL_W'(1);
`ifdef SWEEP_PINGPONG_EN
                    end else if (!down_q && cnt_q == n_q && n_q != '0) begin
                        // top reached: count back down, reusing cnt as the down-step index
                        down_d  = 1'b1;
                        cnt_d   = 16'd1;
                        m_d     = m_q - step_q;
                        state_d = LOAD;
                    end else if (cnt_q == n_q) begin
                        state_d = DONE;
                    end else begin
                        m_d     = down_q ? m_q - step_q : m_q + step_q;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = LOAD;
                    end
`else
                    end else if (cnt_q == n_q) begin
                        state_d = DONE;
                    end else begin
                        m_d     = m_q + step_q;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = LOAD;
                    end
`endif
                end
                DONE: state_d = IDLE;
            endcase
        end
    end
    assign m    = m_q;
    assign en   = en_q;
    assign set  = (state_q == LOAD);
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_sweep_scheduler.sv
// tb_sweep_scheduler: directed and randomized sweeps checked every cycle against
// a schedule model (word list, set period, done cycle) plus literal reference sweeps.
`timescale 1ns/1ps
module tb_sweep_scheduler;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [31:0] m_start = '0, m_step = '0;
    logic [15:0] n_steps = '0;
    logic [23:0] dwell = '0;
    logic [31:0] m;
    logic        set, en, busy, done;
    int tests = 0, fails = 0;
    int cyc = 0, t_start = 0;

    sweep_scheduler #(.DWELL_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .m_start(m_start), .m_step(m_step), .n_steps(n_steps), .dwell(dwell),
        .m(m), .set(set), .en(en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, got, exp);
        end
    endtask

    // model: an accepted start at cycle t0 yields word k set at t0+1+k*(dd+1), done at t0+1+nw*(dd+1)
    logic        act = 1'b0, chk = 1'b0;
    int          t0 = 0, td = 0, dd = 1, nw = 1, mc, mk, mn;
    logic [31:0] w [0:63];
    logic [31:0] m_e = '0;
    logic        en_e = 1'b0, set_e = 1'b0, busy_e = 1'b0, done_e = 1'b0;

    always @(posedge clk) begin
        mc = cyc;
        if (rst) begin
            act = 1'b0; m_e = '0; en_e = 1'b0;
        end else if (act && mc > t0 && mc <= td) begin
            if (abort) begin act = 1'b0; en_e = 1'b0; end
        end else if (abort) begin
            en_e = 1'b0;
        end else if (start) begin
            t0 = mc;
            dd = (dwell == 0) ? 1 : int'(dwell);
            mn = int'(n_steps);
            for (mk = 0; mk <= mn; mk++) w[mk] = m_start + 32'(mk) * m_step;
            nw = mn + 1;
`ifdef SWEEP_PINGPONG_EN
            for (mk = 1; mk <= mn; mk++) w[mn+mk] = m_start + 32'(mn - mk) * m_step;
            nw = 2 * mn + 1;
`endif
            td = t0 + 1 + nw * (dd + 1);
            act = 1'b1; en_e = 1'b1;
        end
        cyc = mc + 1;
        busy_e = act && cyc > t0 && cyc <= td;
        done_e = busy_e && cyc == td;
        set_e  = busy_e && !done_e && ((cyc - t0 - 1) % (dd + 1)) == 0;
        if (busy_e && !done_e) m_e = w[(cyc - t0 - 1) / (dd + 1)];
        chk = 1'b1;
    end

    // per-run log of what the DUT did, relative to the run's start cycle
    int          so_q[$];
    logic [31:0] sm_q[$];
    int          done_off = -1, rel;
    logic [31:0] snap_m [0:63];
    logic        snap_en [0:63];
    logic        snap_busy [0:63];

    always @(negedge clk) begin
        if (chk) begin
            check("set", 32'(set), 32'(set_e));
            check("busy", 32'(busy), 32'(busy_e));
            check("done", 32'(done), 32'(done_e));
            check("en", 32'(en), 32'(en_e));
            check("m", m, m_e);
            rel = cyc - t_start;
            if (rel >= 0 && rel < 64) begin
                snap_m[rel] = m; snap_en[rel] = en; snap_busy[rel] = busy;
            end
            if (set) begin so_q.push_back(rel); sm_q.push_back(m); end
            if (done) done_off = rel;
        end
    end

    task automatic settle();
        for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
        check("settle_busy", 32'(busy), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic go(input logic [31:0] ms, input logic [31:0] st, input logic [15:0] n,
                      input logic [23:0] dw, input int ab_at, input int s2_at, input int chg_at,
                      input int rs_at, input int len, input bit scr);
        so_q.delete(); sm_q.delete(); done_off = -1; t_start = cyc;
        m_start = ms; m_step = st; n_steps = n; dwell = dw;
        for (int r = 0; r < len; r++) begin
            start = (r == 0) || (r == s2_at);
            abort = (r == ab_at);
            rst   = (r == rs_at);
            if (r == chg_at) begin
                m_step = scr ? $urandom : 32'd5;
                if (scr) begin
                    m_start = $urandom; n_steps = 16'($urandom_range(0, 4)); dwell = 24'($urandom_range(0, 3));
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        settle();
    endtask

    task automatic check_ref();
        int          ec[4] = '{1, 6, 11, 16};
        logic [31:0] em[4] = '{32'd157482, 32'd158482, 32'd159482, 32'd160482};
        check("ref_nsets", 32'(so_q.size()), 4);
        for (int i = 0; i < 4 && i < so_q.size(); i++) begin
            check("ref_set_cyc", 32'(so_q[i]), 32'(ec[i]));
            check("ref_set_m", sm_q[i], em[i]);
        end
        check("ref_done_cyc", 32'(done_off), 21);
        check("ref_en1", 32'(snap_en[1]), 1);
    endtask

    initial begin
        int len, ab, s2, ch, rs;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        check("rst_m", m, 0);
        check("rst_en", 32'(en), 0);
        check("rst_busy", 32'(busy), 0);
        go(32'd157482, 32'd1000, 16'd3, 24'd4, -1, -1, -1, -1, 24, 1'b0);
`ifndef SWEEP_PINGPONG_EN
        check_ref();
`endif
        go(32'hFFFFFF00, 32'h200, 16'd1, 24'd0, -1, -1, -1, -1, 8, 1'b0);
`ifndef SWEEP_PINGPONG_EN
        check("wrap_nsets", 32'(so_q.size()), 2);
        if (so_q.size() == 2) begin
            check("wrap_set0_cyc", 32'(so_q[0]), 1);
            check("wrap_set1_cyc", 32'(so_q[1]), 3);
            check("wrap_m0", sm_q[0], 32'hFFFFFF00);
            check("wrap_m1", sm_q[1], 32'h00000100);
        end
`endif
        go(32'd157482, 32'd1000, 16'd3, 24'd4, 8, -1, -1, -1, 14, 1'b0);
        check("abort_nsets", 32'(so_q.size()), 2);
        check("abort_no_done", 32'(done_off), 32'hFFFFFFFF);
        check("abort_busy9", 32'(snap_busy[9]), 0);
        check("abort_en9", 32'(snap_en[9]), 0);
        check("abort_m9", snap_m[9], 32'd158482);
        go(32'd157482, 32'd1000, 16'd3, 24'd4, -1, 3, 4, -1, 24, 1'b0);
`ifndef SWEEP_PINGPONG_EN
        check_ref();
`endif
        go(32'd157482, 32'd1000, 16'd3, 24'd4, -1, -1, -1, 7, 10, 1'b0);
        check("rst_mid_m8", snap_m[8], 0);
        check("rst_mid_en8", 32'(snap_en[8]), 0);
        check("rst_mid_busy8", 32'(snap_busy[8]), 0);
        check("rst_mid_no_done", 32'(done_off), 32'hFFFFFFFF);
        go(32'd157482, 32'd1000, 16'd3, 24'd4, -1, -1, -1, -1, 24, 1'b0);
`ifndef SWEEP_PINGPONG_EN
        check_ref();
`endif
`ifdef SWEEP_PINGPONG_EN
        go(32'd157482, 32'd1000, 16'd2, 24'd2, -1, -1, -1, -1, 20, 1'b0);
        begin
            logic [31:0] pm[5] = '{32'd157482, 32'd158482, 32'd159482, 32'd158482, 32'd157482};
            check("pp_nsets", 32'(so_q.size()), 5);
            for (int i = 0; i < 5 && i < so_q.size(); i++) begin
                check("pp_set_cyc", 32'(so_q[i]), 32'(1 + 3 * i));
                check("pp_set_m", sm_q[i], pm[i]);
            end
            check("pp_done_cyc", 32'(done_off), 16);
        end
`endif
        for (int it = 0; it < 60; it++) begin
            len = $urandom_range(3, 40);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            s2  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            ch  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            rs  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            go($urandom, $urandom, 16'($urandom_range(0, 4)), 24'($urandom_range(0, 3)), ab, s2, ch, rs, len, 1'b1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
